// File: rtl/lemming_track.sv
// Lemming track world model: 1-D position between two walls plus one loadable obstacle, emitting bump pulses.
// Moves and bumps register 1 cycle after the step edge; obs_ready drops only during the step cycle.
module lemming_track #(
    parameter int POS_W     = 8,
    parameter int TRACK_LEN = 16,
    parameter int STEP_DIV  = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             walk_left,
    input  logic             walk_right,
    input  logic             obs_valid,
    output logic             obs_ready,
    input  logic [POS_W-1:0] obs_pos,
    input  logic             obs_clear,
    output logic             obs_err,
    output logic [POS_W-1:0] pos,
    output logic             bump_left,
    output logic             bump_right,
    output logic [CNT_W-1:0] bump_count
);

    localparam int SC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [SC_W-1:0]  STEP_LAST   = SC_W'(STEP_DIV - 1);
    localparam logic [POS_W-1:0] POS_MAX     = POS_W'(TRACK_LEN - 1);
    localparam logic [POS_W-1:0] POS_HOME    = POS_W'(TRACK_LEN / 2);
    localparam logic [POS_W:0]   TRACK_LEN_W = (POS_W + 1)'(TRACK_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    logic [SC_W-1:0]  step_cnt;
    logic             obs_en;
    logic [POS_W-1:0] obs_reg;

    logic             step_now;
    logic [POS_W-1:0] pos_dn;
    logic [POS_W-1:0] pos_up;
    logic             move_l;
    logic             move_r;
    logic             blk_l;
    logic             blk_r;
    logic             bump_any;
    logic             load;
    logic             load_bad;

    always_comb begin
        step_now = (step_cnt == STEP_LAST);
        pos_dn   = pos - POS_W'(1);
        pos_up   = pos + POS_W'(1);
        move_l   = step_now && walk_left && !walk_right;
        move_r   = step_now && walk_right && !walk_left;
        // pos_dn/pos_up may wrap at the walls, but the wall term already blocks there
        blk_l    = (pos == '0) || (obs_en && (obs_reg == pos_dn));
        blk_r    = (pos == POS_MAX) || (obs_en && (obs_reg == pos_up));
        bump_any = (move_l && blk_l) || (move_r && blk_r);
        load     = obs_valid && !step_now;
        load_bad = ({1'b0, obs_pos} >= TRACK_LEN_W) || (obs_pos == pos);
    end

    assign obs_ready = !step_now;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            step_cnt   <= '0;
            pos        <= POS_HOME;
            bump_left  <= 1'b0;
            bump_right <= 1'b0;
            bump_count <= '0;
        end else begin
            step_cnt   <= step_now ? '0 : step_cnt + SC_W'(1);
            bump_left  <= move_l && blk_l;
            bump_right <= move_r && blk_r;
            if (move_l && !blk_l) begin
                pos <= pos_dn;
            end else if (move_r && !blk_r) begin
                pos <= pos_up;
            end
            if (bump_any && (bump_count != CNT_MAX)) begin
                bump_count <= bump_count + CNT_W'(1);
            end
        end
    end

    // Loads never land in the step cycle, so pos compared here is the settled value.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            obs_en  <= 1'b0;
            obs_reg <= '0;
            obs_err <= 1'b0;
        end else begin
            obs_err <= load && load_bad;
            if (load && !load_bad) begin
                obs_en  <= 1'b1;
                obs_reg <= obs_pos;
            end else if (obs_clear) begin
                obs_en  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lemming_track.sv
module tb_lemming_track;

    localparam int POS_W     = 8;
    localparam int TRACK_LEN = 16;
    localparam int STEP_DIV  = 4;
    localparam int HOME      = TRACK_LEN / 2;

    logic             clk = 1'b0;
    logic             areset_n;
    logic             walk_left = 1'b0;
    logic             walk_right = 1'b0;
    logic             obs_valid = 1'b0;
    logic [POS_W-1:0] obs_pos = '0;
    logic             obs_clear = 1'b0;

    logic             obs_ready, obs_err, bump_left, bump_right;
    logic [POS_W-1:0] pos;
    logic [15:0]      bump_count;

    logic             obs_ready2, obs_err2, bump_left2, bump_right2;
    logic [POS_W-1:0] pos2;
    logic [1:0]       bump_count2;

    lemming_track #(.POS_W(POS_W), .TRACK_LEN(TRACK_LEN), .STEP_DIV(STEP_DIV), .CNT_W(16)) dut (
        .clk(clk), .areset_n(areset_n), .walk_left(walk_left), .walk_right(walk_right),
        .obs_valid(obs_valid), .obs_ready(obs_ready), .obs_pos(obs_pos), .obs_clear(obs_clear),
        .obs_err(obs_err), .pos(pos), .bump_left(bump_left), .bump_right(bump_right),
        .bump_count(bump_count)
    );

    lemming_track #(.POS_W(POS_W), .TRACK_LEN(TRACK_LEN), .STEP_DIV(STEP_DIV), .CNT_W(2)) dut_sat (
        .clk(clk), .areset_n(areset_n), .walk_left(walk_left), .walk_right(walk_right),
        .obs_valid(obs_valid), .obs_ready(obs_ready2), .obs_pos(obs_pos), .obs_clear(obs_clear),
        .obs_err(obs_err2), .pos(pos2), .bump_left(bump_left2), .bump_right(bump_right2),
        .bump_count(bump_count2)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: edges counted since reset release; every STEP_DIV-th edge is a step edge.
    int m_n, m_pos, m_obs, m_cnt, m_cnt2;
    bit m_en, m_bl, m_br, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_n = 0; m_pos = HOME; m_obs = 0; m_en = 0;
        m_cnt = 0; m_cnt2 = 0; m_bl = 0; m_br = 0; m_err = 0;
    endtask

    task automatic model_edge();
        int  e;
        int  p0;
        bit  step;
        e    = m_n + 1;
        step = (e % STEP_DIV) == 0;
        p0   = m_pos;
        m_bl = 0; m_br = 0; m_err = 0;
        if (step && walk_left && !walk_right) begin
            if (p0 == 0 || (m_en && m_obs == p0 - 1)) m_bl = 1;
            else m_pos = p0 - 1;
        end
        if (step && walk_right && !walk_left) begin
            if (p0 == TRACK_LEN - 1 || (m_en && m_obs == p0 + 1)) m_br = 1;
            else m_pos = p0 + 1;
        end
        if (m_bl || m_br) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        if (obs_valid && !step) begin
            if (int'(obs_pos) >= TRACK_LEN || int'(obs_pos) == p0) begin
                m_err = 1;
                if (obs_clear) m_en = 0;
            end else begin
                m_en  = 1;
                m_obs = int'(obs_pos);
            end
        end else if (obs_clear) begin
            m_en = 0;
        end
        m_n = e;
    endtask

    task automatic check_all();
        chk("pos", 32'(pos), 32'(m_pos));
        chk("bump_left", 32'(bump_left), 32'(m_bl));
        chk("bump_right", 32'(bump_right), 32'(m_br));
        chk("bump_count", 32'(bump_count), 32'(m_cnt));
        chk("obs_err", 32'(obs_err), 32'(m_err));
        chk("obs_ready", 32'(obs_ready), 32'(((m_n + 1) % STEP_DIV) != 0));
        chk("sat_pos", 32'(pos2), 32'(m_pos));
        chk("sat_bump_count", 32'(bump_count2), 32'(m_cnt2));
    endtask

    task automatic tick(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask

    // Asserts reset between edges, checks it acted without a clock, then releases before the next edge 1.
    task automatic do_reset();
        #2 areset_n = 1'b0;
        #1;
        chk("rst_pos", 32'(pos), 32'(HOME));
        chk("rst_bump_left", 32'(bump_left), 32'd0);
        chk("rst_bump_right", 32'(bump_right), 32'd0);
        chk("rst_bump_count", 32'(bump_count), 32'd0);
        chk("rst_bump_count_sat", 32'(bump_count2), 32'd0);
        chk("rst_obs_err", 32'(obs_err), 32'd0);
        chk("rst_obs_ready", 32'(obs_ready), 32'd1);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        #1;
        chk("init_pos", 32'(pos), 32'(HOME));
        chk("init_bump_count", 32'(bump_count), 32'd0);
        chk("init_bumps", 32'({bump_left, bump_right}), 32'd0);
        chk("init_obs_err", 32'(obs_err), 32'd0);
        model_reset();
        @(negedge clk);
        areset_n = 1'b1;

        // Right wall
        walk_right = 1'b1;
        tick(4);
        chk("wr_e4_pos", 32'(pos), 32'd9);
        tick(24);
        chk("wr_e28_pos", 32'(pos), 32'd15);
        tick(4);
        chk("wr_e32_bump", 32'(bump_right), 32'd1);
        chk("wr_e32_pos", 32'(pos), 32'd15);
        chk("wr_e32_cnt", 32'(bump_count), 32'd1);
        tick(1);
        chk("wr_e33_bump", 32'(bump_right), 32'd0);

        // Left wall
        walk_right = 1'b0;
        do_reset();
        walk_left = 1'b1;
        tick(32);
        chk("wl_e32_pos", 32'(pos), 32'd0);
        tick(4);
        chk("wl_e36_bump", 32'(bump_left), 32'd1);
        chk("wl_e36_pos", 32'(pos), 32'd0);
        chk("wl_e36_cnt", 32'(bump_count), 32'd1);

        // Obstacle at 10 blocks, clear releases it
        walk_left = 1'b0;
        do_reset();
        obs_valid = 1'b1; obs_pos = 8'd10;
        tick(1);
        chk("obs_load_err", 32'(obs_err), 32'd0);
        obs_valid = 1'b0; walk_right = 1'b1;
        tick(3);
        chk("obs_e4_pos", 32'(pos), 32'd9);
        tick(4);
        chk("obs_e8_bump", 32'(bump_right), 32'd1);
        chk("obs_e8_pos", 32'(pos), 32'd9);
        obs_clear = 1'b1;
        tick(1);
        obs_clear = 1'b0;
        tick(3);
        chk("obs_e12_pos", 32'(pos), 32'd10);

        // Rejections and step-cycle handshake
        walk_right = 1'b0;
        do_reset();
        obs_valid = 1'b1; obs_pos = 8'd8;
        tick(1);
        chk("rej_same_err", 32'(obs_err), 32'd1);
        obs_valid = 1'b0;
        tick(1);
        chk("rej_err_drop", 32'(obs_err), 32'd0);
        obs_valid = 1'b1; obs_pos = 8'd20;
        tick(1);
        chk("rej_range_err", 32'(obs_err), 32'd1);
        chk("hs_step_ready", 32'(obs_ready), 32'd0);
        obs_pos = 8'd3;
        tick(1);
        chk("hs_ignored_err", 32'(obs_err), 32'd0);
        chk("hs_ready_back", 32'(obs_ready), 32'd1);
        tick(1);
        obs_valid = 1'b0; walk_left = 1'b1;
        tick(19);
        chk("hs_obs3_pos", 32'(pos), 32'd4);
        chk("hs_obs3_bump", 32'(bump_left), 32'd1);

        // No-move cases
        walk_right = 1'b1;
        tick(20);
        chk("both_hi_pos", 32'(pos), 32'd4);
        walk_left = 1'b0; walk_right = 1'b0;
        tick(20);
        chk("both_lo_pos", 32'(pos), 32'd4);

        // Saturation of the narrow counter
        do_reset();
        walk_right = 1'b1;
        tick(48);
        chk("sat_cnt2", 32'(bump_count2), 32'd3);
        chk("sat_cnt16", 32'(bump_count), 32'd5);

        // Random traffic against the model
        walk_right = 1'b0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                walk_left  = 1'($urandom_range(0, 1));
                walk_right = 1'($urandom_range(0, 1));
            end
            obs_valid = ($urandom_range(0, 4) == 0);
            obs_pos   = 8'($urandom_range(0, 19));
            obs_clear = ($urandom_range(0, 24) == 0);
            tick(1);
        end

        // Mid-run asynchronous reset, then resume
        walk_left = 1'b0; walk_right = 1'b1;
        obs_valid = 1'b0; obs_clear = 1'b0;
        tick(2);
        do_reset();
        tick(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/lemming_track.md
Name: lemming_track

Overview:
- Upstream world-model stage for the lemming walker FSM.
- Consumes the walker's walk_left/walk_right outputs and keeps the lemming's position on a 1-D track bounded by two walls, plus one optional loadable obstacle.
- Produces the bump_left/bump_right pulses that the walker FSM samples to turn around, and counts bumps for debug.

Parameters:
- POS_W, 8, position/obstacle width.
- TRACK_LEN, 16, number of cells. Legal positions 0..TRACK_LEN-1. Constraint: 2 <= TRACK_LEN <= 2^POS_W.
- STEP_DIV, 4, clock cycles per movement step. Must be >= 1; 1 = step every cycle.
- CNT_W, 16, bump counter width.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- areset_n  in  1  asynchronous, active-low reset.
- walk_left  in  1  walker is moving left (level).
- walk_right  in  1  walker is moving right (level).
- obs_valid  in  1  obstacle load request.
- obs_ready  out  1  obstacle load may be accepted this cycle.
- obs_pos  in  POS_W  requested obstacle cell.
- obs_clear  in  1  remove obstacle (level, sampled every cycle).
- obs_err  out  1  one-cycle pulse: load rejected.
- pos  out  POS_W  current lemming cell (registered).
- bump_left  out  1  one-cycle pulse: left move blocked.
- bump_right  out  1  one-cycle pulse: right move blocked.
- bump_count  out  CNT_W  saturating count of bump pulses.

Behaviour:
- Reset, asserted asynchronously, takes effect immediately, including mid-step:
  - pos = TRACK_LEN/2 (integer division).
  - bump_left = bump_right = 0, obs_err = 0, bump_count = 0.
  - Step counter = 0; obstacle disabled (obs_en = 0, obs_reg = 0).
- Step timing:
  - Step counter runs 0..STEP_DIV-1, then wraps to 0.
  - The cycle with counter == STEP_DIV-1 is the step cycle. Movement is evaluated at the rising edge ending that cycle.
  - The first step edge after reset release is the STEP_DIV-th edge.
- Move evaluation at a step edge:
  - Both walk signals equal (both 0 or both 1): no move, no bump.
  - walk_left only:
    - Blocked if pos == 0, or (obs_en and obs_reg == pos-1).
    - Blocked: pos holds, bump_left = 1. Otherwise pos <= pos-1.
  - walk_right only:
    - Blocked if pos == TRACK_LEN-1, or (obs_en and obs_reg == pos+1).
    - Blocked: pos holds, bump_right = 1. Otherwise pos <= pos+1.
  - pos never leaves 0..TRACK_LEN-1. There is no wrap-around.
- Bump outputs:
  - Registered, high for exactly the one cycle after the step edge, then 0.
  - Never both high in the same cycle.
  - The walker FSM therefore turns at the next edge, and its new direction is seen at the following step.
- bump_count:
  - Increments by 1 on each edge where a bump is registered.
  - Saturates at 2^CNT_W-1; no wrap.
- Obstacle interface:
  - obs_ready = 0 during the step cycle and 1 otherwise, so obstacle changes never coincide with move evaluation.
  - A load is accepted when obs_valid and obs_ready are both 1 at an edge.
  - Rejected if obs_pos >= TRACK_LEN or obs_pos == pos: obs_err pulses 1 cycle and obstacle state is unchanged.
  - Otherwise obs_reg <= obs_pos and obs_en <= 1. Obstacle state is internal only.
  - obs_valid while obs_ready = 0 is ignored; the requester holds it until accepted.
  - obs_clear = 1 at an edge sets obs_en <= 0.
  - An accepted load and obs_clear at the same edge: the load wins.
  - A rejected load plus obs_clear at the same edge: clear applies and obs_err pulses.
- The lemming never occupies the obstacle cell, by construction.

Test Plan (defaults, reset released before edge 1):
- Wall bump right: walk_right=1 held from reset.
  - pos 8→9 at edge 4, steps every 4 edges, pos=15 at edge 28.
  - Edge 32: pos stays 15, bump_right=1 for one cycle only, bump_count=1.
- Wall bump left: walk_left=1 held.
  - pos reaches 0 at edge 32.
  - Edge 36: bump_left pulse, pos=0, bump_count increments.
- Obstacle: load obs_pos=10 (accepted, obs_err=0), then walk_right=1.
  - pos 8→9, next step bump_right with pos=9.
  - obs_clear, then next step pos=10.
- Load rejection/handshake:
  - obs_pos=8 while pos=8 → obs_err pulse, no effect.
  - obs_pos=20 → obs_err pulse.
  - obs_valid in a step cycle → obs_ready=0, accepted on the following edge.
- No-move cases: walk_left=walk_right=1, or both 0, for 5 steps → pos constant, no bumps.
- Reset/saturation:
  - areset_n low between edges mid-run → pos=8, bumps=0, bump_count=0 immediately, without waiting for a clock edge.
  - With CNT_W=2, 5 wall bumps → bump_count stays 3.
